// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - shared OBI initiator-select encodings
package obi_pkg;

  // Initiator select encodings, shared with obi_demux
  localparam logic [1:0] SEL_NONE  = 2'd0;
  localparam logic [1:0] SEL_PORT1 = 2'd1;
  localparam logic [1:0] SEL_PORT2 = 2'd2;

  // Port that should be favoured after the given port has been served
  function automatic logic [1:0] other_port(input logic [1:0] sel);
    return (sel == SEL_PORT2) ? SEL_PORT1 : SEL_PORT2;
  endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// rtl/obi_id_fifo.sv - small FIFO holding initiator IDs of outstanding transactions
module obi_id_fifo #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Pointer advance with explicit wrap so DEPTH=1 keeps the pointer at zero
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    if (ptr == PW'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + PW'(1);
  endfunction

  // Writes into a full FIFO and reads from an empty one are ignored
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage and write pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q        <= ptr_next(wr_ptr_q);
    end
  end

  // Read pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
    end else if (do_pop) begin
      rd_ptr_q <= ptr_next(rd_ptr_q);
    end
  end

  // Occupancy; simultaneous push and pop leave it unchanged
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/obi_mux_2_to_1.sv
// rtl/obi_mux_2_to_1.sv - two-initiator to one-responder OBI arbiter with in-order response routing
module obi_mux_2_to_1
  import obi_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 2,
  parameter  int FIXED_PRIO      = 0,
  localparam int OCW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic           clk_i,
  input  logic           rst_i,

  input  logic           in1_req_i,
  output logic           in1_gnt_o,
  input  logic [31:0]    in1_addr_i,
  input  logic           in1_we_i,
  input  logic [3:0]     in1_be_i,
  input  logic [31:0]    in1_wdata_i,
  output logic           in1_rvalid_o,
  output logic [31:0]    in1_rdata_o,

  input  logic           in2_req_i,
  output logic           in2_gnt_o,
  input  logic [31:0]    in2_addr_i,
  input  logic           in2_we_i,
  input  logic [3:0]     in2_be_i,
  input  logic [31:0]    in2_wdata_i,
  output logic           in2_rvalid_o,
  output logic [31:0]    in2_rdata_o,

  output logic           out_req_o,
  input  logic           out_gnt_i,
  output logic [31:0]    out_addr_o,
  output logic           out_we_o,
  output logic [3:0]     out_be_o,
  output logic [31:0]    out_wdata_o,
  input  logic           out_rvalid_i,
  input  logic [31:0]    out_rdata_i,

  output logic [OCW-1:0] outstanding_o,
  output logic           resp_err_o
);

  logic [1:0] sel;
  logic [1:0] sel_q;
  logic [1:0] rr_q;
  logic       lock_q;
  logic       any_req;
  logic       accept;
  logic       sel_is_port2;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_head;
  logic       resp_pop;
  logic       resp_err_q;

  // Arbitration: a stalled request keeps its initiator until accepted
  always_comb begin
    sel = SEL_NONE;
    if (lock_q) begin
      sel = sel_q;
    end else if (in1_req_i && !in2_req_i) begin
      sel = SEL_PORT1;
    end else if (in2_req_i && !in1_req_i) begin
      sel = SEL_PORT2;
    end else if (in1_req_i && in2_req_i) begin
      if (FIXED_PRIO != 0) begin
        sel = SEL_PORT1;
      end else begin
        sel = rr_q;
      end
    end
  end

  assign any_req      = in1_req_i | in2_req_i;
  assign out_req_o    = any_req & ~fifo_full & ~rst_i;
  assign accept       = out_req_o & out_gnt_i;
  assign sel_is_port2 = (sel == SEL_PORT2);

  // Address-phase fields default to in1 when nobody is selected
  assign out_addr_o  = sel_is_port2 ? in2_addr_i  : in1_addr_i;
  assign out_we_o    = sel_is_port2 ? in2_we_i    : in1_we_i;
  assign out_be_o    = sel_is_port2 ? in2_be_i    : in1_be_i;
  assign out_wdata_o = sel_is_port2 ? in2_wdata_i : in1_wdata_i;

  assign in1_gnt_o = accept & (sel == SEL_PORT1);
  assign in2_gnt_o = accept & (sel == SEL_PORT2);

  // Lock holds the stalled selection so the address phase stays stable
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q <= 1'b0;
      sel_q  <= SEL_NONE;
    end else if (accept) begin
      lock_q <= 1'b0;
    end else if (out_req_o) begin
      lock_q <= 1'b1;
      sel_q  <= sel;
    end
  end

  // Round-robin pointer moves to the initiator that was not just served
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= SEL_PORT1;
    end else if (accept) begin
      rr_q <= other_port(sel);
    end
  end

  // One entry per accepted transaction: 0 = in1, 1 = in2
  obi_id_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (accept),
    .push_data_i (sel_is_port2),
    .pop_i       (resp_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (outstanding_o)
  );

  // Responses are routed to the oldest outstanding initiator
  assign resp_pop     = out_rvalid_i & ~fifo_empty;
  assign in1_rvalid_o = resp_pop & ~fifo_head;
  assign in2_rvalid_o = resp_pop & fifo_head;
  assign in1_rdata_o  = out_rdata_i;
  assign in2_rdata_o  = out_rdata_i;

  // Sticky flag for a response with nothing outstanding
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_err_q <= 1'b0;
    end else if (out_rvalid_i && fifo_empty) begin
      resp_err_q <= 1'b1;
    end
  end

  assign resp_err_o = resp_err_q;

endmodule
